// File: rtl/btn_press_ctrl.sv
// Debounces a synchronized button level and turns it into single-cycle press,
// release and auto-repeat events, plus the debounced level and a long-press flag.
module btn_press_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 10_000_000
) (
  input  logic clk_in,
  input  logic reset,
  input  logic btn_in,
  output logic press_pulse,
  output logic repeat_pulse,
  output logic release_pulse,
  output logic btn_held,
  output logic long_press
);

  localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int RW   = $clog2(RMAX);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] H_LAST = RW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CYCLES - 1);
  localparam bit D_ONE = (DEBOUNCE_CYCLES == 1);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, REL_WAIT} state_t;

  state_t          state_reg, state_next;
  logic [DW-1:0]   dcnt_reg, dcnt_next;
  logic [RW-1:0]   rcnt_reg, rcnt_next;
  logic            press_reg, press_next;
  logic            repeat_reg, repeat_next;
  logic            release_reg, release_next;
  logic            held_reg, held_next;
  logic            long_reg, long_next;

  logic            do_press, do_release, advance;
  logic [RW-1:0]   rcnt_last;

  // The first interval runs to HOLD_CYCLES; once long_press is set, intervals are REPEAT_CYCLES.
  assign rcnt_last = long_reg ? R_LAST : H_LAST;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      dcnt_reg    <= '0;
      rcnt_reg    <= '0;
      press_reg   <= 1'b0;
      repeat_reg  <= 1'b0;
      release_reg <= 1'b0;
      held_reg    <= 1'b0;
      long_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      dcnt_reg    <= dcnt_next;
      rcnt_reg    <= rcnt_next;
      press_reg   <= press_next;
      repeat_reg  <= repeat_next;
      release_reg <= release_next;
      held_reg    <= held_next;
      long_reg    <= long_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    dcnt_next    = dcnt_reg;
    rcnt_next    = rcnt_reg;
    press_next   = 1'b0;
    repeat_next  = 1'b0;
    release_next = 1'b0;
    held_next    = held_reg;
    long_next    = long_reg;
    do_press     = 1'b0;
    do_release   = 1'b0;
    advance      = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (btn_in) begin
          if (D_ONE) begin
            do_press = 1'b1;
          end else begin
            state_next = PRESS_WAIT;
            dcnt_next  = DW'(1);
          end
        end
      end
      PRESS_WAIT: begin
        if (!btn_in) begin
          state_next = IDLE;
          dcnt_next  = '0;
        end else if (dcnt_reg == D_LAST) begin
          do_press = 1'b1;
        end else begin
          dcnt_next = dcnt_reg + DW'(1);
        end
      end
      HELD: begin
        if (!btn_in) begin
          if (D_ONE) begin
            do_release = 1'b1;
          end else begin
            state_next = REL_WAIT;
            dcnt_next  = DW'(1);
          end
        end else begin
          advance = 1'b1;
        end
      end
      REL_WAIT: begin
        // A high sample here counts toward the repeat timer, so a bounce only
        // delays the schedule by the number of low samples.
        if (btn_in) begin
          state_next = HELD;
          dcnt_next  = '0;
          advance    = 1'b1;
        end else if (dcnt_reg == D_LAST) begin
          do_release = 1'b1;
        end else begin
          dcnt_next = dcnt_reg + DW'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    if (do_press) begin
      state_next = HELD;
      dcnt_next  = '0;
      rcnt_next  = '0;
      press_next = 1'b1;
      held_next  = 1'b1;
    end

    if (do_release) begin
      state_next   = IDLE;
      dcnt_next    = '0;
      rcnt_next    = '0;
      release_next = 1'b1;
      held_next    = 1'b0;
      long_next    = 1'b0;
    end

    if (advance) begin
      if (rcnt_reg == rcnt_last) begin
        rcnt_next   = '0;
        repeat_next = 1'b1;
        long_next   = 1'b1;
      end else begin
        rcnt_next = rcnt_reg + RW'(1);
      end
    end
  end

  assign press_pulse   = press_reg;
  assign repeat_pulse  = repeat_reg;
  assign release_pulse = release_reg;
  assign btn_held      = held_reg;
  assign long_press    = long_reg;

endmodule
